// File: rtl/logic_spi_master.sv
// rtl/logic_spi_master.sv - SPI mode-0 master: opcode byte then length data bytes, full duplex.
module logic_spi_master #(
    parameter int CLK_DIV   = 2,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 start,
    input  logic [7:0]           opcode,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [7:0]           wr_data,
    output logic                 wr_ack,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 spi_nss,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;

    state_t               state, state_next;
    logic [7:0]           cnt;
    logic [7:0]           tx_sr;
    logic [7:0]           rx_sr;
    logic [2:0]           bit_cnt;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 first_byte;
    logic                 tick;
    logic                 last_fall;

    assign tick      = (cnt == DIV_LAST);
    // The 8th falling edge of the current byte happens at the end of this cycle.
    assign last_fall = (state == SHIFT) && tick && spi_sck && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = SETUP;
            SETUP: if (tick) state_next = SHIFT;
            SHIFT: if (last_fall && (remaining == LEN_ZERO)) state_next = HOLD;
            HOLD:  if (tick) state_next = GAP;
            GAP:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        done   = (state == GAP) && (cnt == 8'd0);
        wr_ack = nreset && last_fall && (remaining != LEN_ZERO);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt        <= 8'd0;
            tx_sr      <= 8'd0;
            rx_sr      <= 8'd0;
            bit_cnt    <= 3'd0;
            remaining  <= '0;
            first_byte <= 1'b0;
            rd_data    <= 8'd0;
            rd_valid   <= 1'b0;
            spi_nss    <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == IDLE || state != state_next || tick) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        spi_nss    <= 1'b0;
                        spi_sck    <= 1'b0;
                        spi_mosi   <= opcode[7];
                        tx_sr      <= {opcode[6:0], 1'b0};
                        rx_sr      <= 8'd0;
                        bit_cnt    <= 3'd0;
                        remaining  <= length;
                        first_byte <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        spi_sck <= ~spi_sck;
                        if (!spi_sck) begin
                            rx_sr <= {rx_sr[6:0], spi_miso};
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt != 3'd7) begin
                                spi_mosi <= tx_sr[7];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end else begin
                                // Opcode-phase receive bits are dropped on purpose.
                                if (!first_byte) begin
                                    rd_data  <= rx_sr;
                                    rd_valid <= 1'b1;
                                end
                                first_byte <= 1'b0;
                                if (remaining != LEN_ZERO) begin
                                    spi_mosi  <= wr_data[7];
                                    tx_sr     <= {wr_data[6:0], 1'b0};
                                    remaining <= remaining - LEN_ONE;
                                end else begin
                                    spi_mosi <= 1'b0;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        spi_nss  <= 1'b1;
                        spi_mosi <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_spi_master.sv
// tb/tb_logic_spi_master.sv - directed bench for logic_spi_master with a mode-0 slave model.
module tb_logic_spi_master;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    opcode = 8'd0;
    logic [LW-1:0] length = '0;
    logic [7:0]    wr_data;
    logic          wr_ack;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          spi_nss;
    logic          spi_sck;
    logic          spi_mosi;
    logic          spi_miso = 1'b0;

    logic_spi_master #(.CLK_DIV(2), .LEN_WIDTH(LW)) dut (
        .clk(clk), .nreset(nreset), .start(start), .opcode(opcode), .length(length),
        .wr_data(wr_data), .wr_ack(wr_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .spi_nss(spi_nss), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Host side: wr_data presents the next table entry, indexed by acks seen so far.
    logic [7:0] wtab [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int ack_base = 0;
    int ack_total = 0, rv_total = 0, done_total = 0, mosi_bad = 0;
    int low_cnt = 0, last_low = 0, hi_cnt = 0, last_hi = 0;
    logic [7:0] rd_q [0:1023];

    initial begin
        wr_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            wr_data = wtab[(ack_total - ack_base) & 3];
        end
    end

    always @(negedge clk) begin
        if (wr_ack === 1'b1) ack_total++;
        if (rd_valid === 1'b1) begin
            if (rv_total < 1024) rd_q[rv_total] = rd_data;
            rv_total++;
        end
        if (done === 1'b1) done_total++;
        if (spi_nss === 1'b1 && spi_mosi !== 1'b0) mosi_bad++;
        if (spi_nss === 1'b0) begin
            if (hi_cnt != 0) last_hi = hi_cnt;
            hi_cnt = 0;
            low_cnt++;
        end else begin
            if (low_cnt != 0) last_low = low_cnt;
            low_cnt = 0;
            hi_cnt++;
        end
    end

    // Slave model: mode-0 shift register, logs every received byte.
    logic       echo = 1'b0;
    logic [7:0] resp [0:3] = '{8'h00, 8'hA5, 8'h00, 8'h00};
    logic [7:0] s_log [0:255];
    logic [7:0] s_rx = 8'd0;
    int sbits = 0;
    int s_nbytes = 0;

    always @(posedge spi_sck or posedge spi_nss) begin
        if (spi_nss === 1'b1) begin
            if (sbits != 0) s_nbytes = sbits / 8;
            sbits = 0;
        end else begin
            s_rx = {s_rx[6:0], spi_mosi};
            sbits++;
            if (sbits % 8 == 0) s_log[sbits / 8 - 1] = s_rx;
        end
    end

    always @(negedge spi_sck or negedge spi_nss) begin
        if (spi_nss === 1'b0) begin
            int bi;
            int bt;
            logic [7:0] b;
            bi = sbits / 8;
            bt = sbits % 8;
            if (echo) b = (bi == 0) ? 8'h00 : s_log[bi - 1];
            else      b = resp[bi & 3];
            spi_miso = b[7 - bt];
        end
    end

    int s_ack, s_rv, s_done;

    task automatic snap();
        s_ack  = ack_total;
        s_rv   = rv_total;
        s_done = done_total;
    endtask

    task automatic launch(input logic [7:0] op, input logic [LW-1:0] len);
        @(negedge clk);
        opcode   = op;
        length   = len;
        start    = 1'b1;
        ack_base = ack_total;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset with start held: outputs at reset values, start ignored.
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_nss", spi_nss, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        start = 1'b0;
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_start_ignored", busy, 0);

        // Single read.
        echo = 1'b0;
        snap();
        launch(8'h02, 1);
        @(negedge clk);
        chk("rd1_setup_busy", busy, 1);
        chk("rd1_setup_nss", spi_nss, 0);
        chk("rd1_setup_mosi", spi_mosi, 0);
        chk("rd1_setup_sck", spi_sck, 0);
        wait_idle("rd1", 200);
        chk("rd1_nbytes", s_nbytes, 2);
        chk("rd1_mosi0", s_log[0], 8'h02);
        chk("rd1_mosi1", s_log[1], 8'h11);
        chk("rd1_acks", ack_total - s_ack, 1);
        chk("rd1_rvs", rv_total - s_rv, 1);
        chk("rd1_rd_data", rd_q[s_rv], 8'hA5);
        chk("rd1_low", last_low, 68);
        chk("rd1_done", done_total - s_done, 1);

        // Opcode only.
        snap();
        launch(8'h03, 0);
        wait_idle("op0", 200);
        chk("op0_nbytes", s_nbytes, 1);
        chk("op0_mosi0", s_log[0], 8'h03);
        chk("op0_low", last_low, 36);
        chk("op0_acks", ack_total - s_ack, 0);
        chk("op0_rvs", rv_total - s_rv, 0);
        chk("op0_done", done_total - s_done, 1);

        // Burst with echoing slave; opcode MSB set.
        echo = 1'b1;
        snap();
        launch(8'h9B, 3);
        @(negedge clk);
        chk("bst_setup_mosi", spi_mosi, 1);
        wait_idle("bst", 400);
        chk("bst_nbytes", s_nbytes, 4);
        chk("bst_mosi0", s_log[0], 8'h9B);
        chk("bst_mosi1", s_log[1], 8'h11);
        chk("bst_mosi2", s_log[2], 8'h22);
        chk("bst_mosi3", s_log[3], 8'h33);
        chk("bst_acks", ack_total - s_ack, 3);
        chk("bst_rvs", rv_total - s_rv, 3);
        chk("bst_rd0", rd_q[s_rv], 8'h9B);
        chk("bst_rd1", rd_q[s_rv + 1], 8'h11);
        chk("bst_rd2", rd_q[s_rv + 2], 8'h22);
        chk("bst_low", last_low, 132);
        chk("bst_done", done_total - s_done, 1);

        // Start collision during SHIFT.
        echo = 1'b0;
        snap();
        launch(8'h3E, 1);
        repeat (20) @(negedge clk);
        opcode = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("col", 200);
        chk("col_nbytes", s_nbytes, 2);
        chk("col_mosi0", s_log[0], 8'h3E);
        chk("col_low", last_low, 68);
        chk("col_done", done_total - s_done, 1);

        // Reset after the 4th rising edge of data byte 1.
        begin
            int n;
            snap();
            launch(8'h0F, 1);
            n = 0;
            while (sbits < 12 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("mid_reach_timeout", 32'(n < 200), 32'd1);
            nreset = 1'b0;
            @(posedge clk);
            #1;
            nreset = 1'b1;
            @(negedge clk);
            chk("mid_nss", spi_nss, 1);
            chk("mid_sck", spi_sck, 0);
            chk("mid_busy", busy, 0);
            chk("mid_rd_data", rd_data, 8'h00);
            repeat (80) @(negedge clk);
            chk("mid_no_done", done_total - s_done, 0);
            chk("mid_no_rv", rv_total - s_rv, 0);
        end
        snap();
        launch(8'h02, 1);
        wait_idle("post", 200);
        chk("post_done", done_total - s_done, 1);
        chk("post_rvs", rv_total - s_rv, 1);
        chk("post_rd_data", rd_q[s_rv], 8'hA5);

        // Back-to-back with start held high.
        begin
            int n;
            snap();
            @(negedge clk);
            opcode = 8'h03;
            length = 0;
            start = 1'b1;
            ack_base = ack_total;
            n = 0;
            while (done_total < s_done + 2 && n < 300) begin
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            chk("b2b_timeout", 32'(n < 300), 32'd1);
            wait_idle("b2b", 200);
            chk("b2b_gap_min", 32'(last_hi >= 3), 32'd1);
            chk("b2b_done", done_total - s_done, 2);
        end

        // Maximum length: counter must not wrap.
        echo = 1'b1;
        snap();
        launch(8'hC3, 8'd255);
        wait_idle("max", 9000);
        chk("max_low", last_low, 8196);
        chk("max_nbytes", s_nbytes, 256);
        chk("max_acks", ack_total - s_ack, 255);
        chk("max_rvs", rv_total - s_rv, 255);
        chk("max_rd_last", rd_q[s_rv + 254], 8'h22);
        chk("max_done", done_total - s_done, 1);

        chk("mosi_low_when_deselected", mosi_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
